// File: rtl/axil_cmd_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ simple command requesters onto one
// AXI4-Lite master port, one transaction at a time, and pulses the response back.
module axil_cmd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_wstrb,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_resp,

    output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
    output logic [2:0]                       m_axil_awprot,
    output logic                             m_axil_awvalid,
    input  logic                             m_axil_awready,
    output logic [DATA_WIDTH-1:0]            m_axil_wdata,
    output logic [STRB_WIDTH-1:0]            m_axil_wstrb,
    output logic                             m_axil_wvalid,
    input  logic                             m_axil_wready,
    input  logic [1:0]                       m_axil_bresp,
    input  logic                             m_axil_bvalid,
    output logic                             m_axil_bready,
    output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
    output logic [2:0]                       m_axil_arprot,
    output logic                             m_axil_arvalid,
    input  logic                             m_axil_arready,
    input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
    input  logic [1:0]                       m_axil_rresp,
    input  logic                             m_axil_rvalid,
    output logic                             m_axil_rready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        grant_p1;
    logic                    write_p1;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic [DATA_WIDTH-1:0]   wdata_p1;
    logic [STRB_WIDTH-1:0]   wstrb_p1;
    logic                    aw_pend;
    logic                    w_pend;
    logic [DATA_WIDTH-1:0]   rdata_p2;
    logic [1:0]              resp_p2;

    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W:0]          cand;

    // Search starts one past the last winner; one subtraction wraps since cand < 2*NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ))
                cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = req_write[win_idx] ? WR_REQ : RD_REQ;
            WR_REQ:  if (!(aw_pend && !m_axil_awready) && !(w_pend && !m_axil_wready))
                         state_nxt = WR_RESP;
            WR_RESP: if (m_axil_bvalid) state_nxt = RSP;
            RD_REQ:  if (m_axil_arready) state_nxt = RD_DATA;
            RD_DATA: if (m_axil_rvalid) state_nxt = RSP;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p1: command captured at grant; p2: response captured from B/R channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= LAST_IDX;
            grant_p1   <= '0;
            write_p1   <= 1'b0;
            addr_p1    <= '0;
            wdata_p1   <= '0;
            wstrb_p1   <= '0;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            rdata_p2   <= '0;
            resp_p2    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        last_grant <= win_idx;
                        grant_p1   <= win_idx;
                        write_p1   <= req_write[win_idx];
                        addr_p1    <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_p1   <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        wstrb_p1   <= req_wstrb[win_idx*STRB_WIDTH +: STRB_WIDTH];
                        aw_pend    <= 1'b1;
                        w_pend     <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (m_axil_awready) aw_pend <= 1'b0;
                    if (m_axil_wready)  w_pend  <= 1'b0;
                end
                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        resp_p2  <= m_axil_bresp;
                        rdata_p2 <= '0;
                    end
                end
                RD_DATA: begin
                    if (m_axil_rvalid) begin
                        resp_p2  <= m_axil_rresp;
                        rdata_p2 <= m_axil_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated with rst_n so nothing is offered while reset is held.
    assign req_ready = (rst_n && state == IDLE && win_found) ? (NUM_REQ'(1) << win_idx) : '0;
    assign rsp_valid = (state == RSP) ? (NUM_REQ'(1) << grant_p1) : '0;
    assign rsp_rdata = rdata_p2;
    assign rsp_resp  = resp_p2;

    assign m_axil_awaddr  = addr_p1;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = (state == WR_REQ) && aw_pend;
    assign m_axil_wdata   = wdata_p1;
    assign m_axil_wstrb   = wstrb_p1;
    assign m_axil_wvalid  = (state == WR_REQ) && w_pend;
    assign m_axil_bready  = (state == WR_RESP);
    assign m_axil_araddr  = addr_p1;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = (state == RD_REQ);
    assign m_axil_rready  = (state == RD_DATA);

    logic unused_write;
    assign unused_write = write_p1;

endmodule

// File: doc/axil_cmd_arbiter.md
# axil_cmd_arbiter

Round-robin arbiter and AXI4-Lite master sequencer that shares one AXI4-Lite slave port between NUM_REQ simple command requesters. It accepts one command at a time, drives the AW/W/B or AR/R channel handshakes, and returns the response to the granted requester. It sits between internal register-access clients and the AXI4-Lite interconnect. Its AXI behaviour must satisfy the environment's AXI4-Lite protocol assertions: VALID is held until READY, address and data are stable while VALID is high, and VALID drops after the handshake.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 16, AXI address width
- DATA_WIDTH, 32, AXI data width
- STRB_WIDTH, 4, write strobe width (DATA_WIDTH/8)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  one-hot command accept
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_wstrb  in  NUM_REQ*STRB_WIDTH  packed write strobes
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  captured BRESP/RRESP
- m_axil_awaddr / m_axil_awprot / m_axil_awvalid  out  ADDR_WIDTH / 3 / 1  write address channel; awprot is constant 3'b000
- m_axil_awready  in  1  write address ready
- m_axil_wdata / m_axil_wstrb / m_axil_wvalid  out  DATA_WIDTH / STRB_WIDTH / 1  write data channel
- m_axil_wready  in  1  write data ready
- m_axil_bresp / m_axil_bvalid  in  2 / 1  write response
- m_axil_bready  out  1  write response ready
- m_axil_araddr / m_axil_arprot / m_axil_arvalid  out  ADDR_WIDTH / 3 / 1  read address channel; arprot is constant 3'b000
- m_axil_arready  in  1  read address ready
- m_axil_rdata / m_axil_rresp / m_axil_rvalid  in  DATA_WIDTH / 2 / 1  read data
- m_axil_rready  out  1  read data ready

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- **IDLE, arbitration:**
  - Round-robin, starting the search at requester last_grant+1 (mod NUM_REQ).
  - The winner gets req_ready asserted combinationally in the same cycle.
  - On that edge: latch write, addr, wdata, wstrb and the grant index, set last_grant to the winner, then go to WR_REQ or RD_REQ.
- **WR_REQ:**
  - awvalid and wvalid are asserted together.
  - Each one clears independently on its own handshake (valid & ready), in the cycle after that handshake.
  - When both handshakes are done (same or different cycles), go to WR_RESP.
- **WR_RESP:** bready=1. On bvalid, capture bresp, set rsp_rdata=0, and go to RSP.
- **RD_REQ:** arvalid=1 until arready, then go to RD_DATA.
- **RD_DATA:** rready=1. On rvalid, capture rdata and rresp, and go to RSP.
- **RSP:**
  - rsp_valid[grant]=1 for exactly one cycle.
  - rsp_resp and rsp_rdata are valid in the same cycle.
  - Next state is IDLE. There is no response backpressure.
- Only one transaction is outstanding. No other requester sees req_ready until RSP is finished.
- SLVERR (2'b10) and DECERR (2'b11) pass through unchanged; the block does not retry.
- AXI address, data and strobe outputs come from the latched registers, so they are stable for the whole transaction.
- No VALID output depends combinationally on any READY input.

## Timing
- **Reset (rst_n=0):**
  - Asynchronous. All outputs are 0, the state is IDLE, and last_grant=NUM_REQ-1, so requester 0 wins first.
  - Asserting reset mid-transaction abandons the transaction immediately; VALIDs drop in the same cycle.
- **Write, zero wait states:**
  - Cycle 0: req_ready.
  - Cycle 1: awvalid, wvalid, with awready and wready.
  - Cycle 2: bready, with bvalid.
  - Cycle 3: rsp_valid.
  - Cycle 4: IDLE, earliest next req_ready.
- **Read, zero wait states:**
  - Cycle 0: req_ready.
  - Cycle 1: arvalid, with arready.
  - Cycle 2: rready, with rvalid.
  - Cycle 3: rsp_valid.
- Every extra READY/VALID wait cycle from the slave adds one cycle of latency.
- Maximum throughput is one command per 4 cycles.
- A requester must hold req_valid and its fields until req_ready. The arbiter never deasserts req_ready of an asserted requester once shown within a cycle.
- awready before wready, or wready before awready: the channel already handshaken stays low; the other channel stays asserted.
- bvalid arriving while awvalid/wvalid are still outstanding is not legal from the slave; it is ignored until WR_RESP.

## Test plan
- **Single write.** Requester 0 writes addr 0x0010, wdata 0xDEADBEEF, wstrb 4'hF; slave has zero wait states and returns OKAY. Required: awaddr=0x0010 and wdata=0xDEADBEEF in cycle 1; rsp_valid=2'b01 in cycle 3; rsp_resp=0.
- **Single read.** Requester 1 reads addr 0x0020; slave returns rdata=0x12345678 after 3 wait cycles on rvalid. Required: rsp_valid=2'b10 with rsp_rdata=0x12345678 in cycle 6.
- **Round-robin.** Both requesters hold req_valid continuously for 4 commands. Required: grant order 0,1,0,1; a second req_ready is never asserted before the prior rsp_valid.
- **Skewed AW/W ready.** awready in cycle 1, wready in cycle 4. Required: awvalid low from cycle 2; wvalid high through cycle 4 then low; wdata stable throughout; bready asserted in cycle 5.
- **Error response.** Read with rresp=2'b10 (SLVERR). Required: rsp_resp=2'b10 and no retry.
- **Reset mid-transaction.** rst_n pulsed low while arvalid=1. Required: all outputs 0 immediately; after release, requester 0 is granted first.
